// File: rtl/flash_host_arbiter.sv
// Two-master arbiter for the flash controller Avalon-MM slave port.
// m0 is the host CPU and m1 is the erase/program engine. The two masters share the port round-robin.
// A lock lets the current owner keep the port between the accesses of a command sequence.
// Watchdogs flag a flash that stalls too long and a lock that idles too long.
//
// Handshake: a master requests with read_i or write_i and holds its command
// until it samples waitrequest_o low at a rising clock edge. That edge
// completes the transfer. The slave side follows the same rule with
// s_waitrequest_i. No command ever reaches the slave outside ACTIVE.
module flash_host_arbiter #(
    parameter int WAIT_MAX = 1024,
    parameter int LOCK_MAX = 256,
    parameter int CNT_W    = 11
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [3:0]  m0_addr_i,
    input  logic [15:0] m0_data_i,
    input  logic        m0_write_i,
    input  logic        m0_read_i,
    input  logic        m0_byteenable_i,
    input  logic        m0_lock_i,
    output logic [15:0] m0_data_o,
    output logic        m0_waitrequest_o,
    input  logic [3:0]  m1_addr_i,
    input  logic [15:0] m1_data_i,
    input  logic        m1_write_i,
    input  logic        m1_read_i,
    input  logic        m1_byteenable_i,
    input  logic        m1_lock_i,
    output logic [15:0] m1_data_o,
    output logic        m1_waitrequest_o,
    output logic [3:0]  s_addr_o,
    output logic [15:0] s_data_o,
    output logic        s_write_o,
    output logic        s_read_o,
    output logic        s_byteenable_o,
    input  logic [15:0] s_data_i,
    input  logic        s_waitrequest_i,
    output logic [1:0]  grant_o,
    output logic        timeout_o,
    output logic        lock_err_o,
    input  logic        clr_i,
    output logic [1:0]  dbg_state_o
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACTIVE = 2'd1;
    localparam logic [1:0] ST_HOLD   = 2'd2;

    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(WAIT_MAX - 1);
    localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_MAX - 1);

    logic [1:0]       r_state;
    logic             r_owner;
    logic             r_last;
    logic [CNT_W-1:0] r_wcnt;
    logic [CNT_W-1:0] r_lcnt;
    logic             r_timeout;
    logic             r_lock_err;

    logic             w_req0;
    logic             w_req1;
    logic             w_own_req;
    logic             w_own_lock;
    logic             w_active;
    logic [1:0]       w_state_nxt;
    logic             w_owner_nxt;
    logic             w_last_nxt;
    logic [CNT_W-1:0] w_wcnt_nxt;
    logic [CNT_W-1:0] w_lcnt_nxt;
    logic             w_set_timeout;
    logic             w_lock_err_nxt;

    assign w_req0     = m0_read_i | m0_write_i;
    assign w_req1     = m1_read_i | m1_write_i;
    assign w_own_req  = r_owner ? w_req1 : w_req0;
    assign w_own_lock = r_owner ? m1_lock_i : m0_lock_i;
    assign w_active   = (r_state == ST_ACTIVE);

    // Next-state, arbitration and watchdog counter logic
    always_comb begin
        w_state_nxt    = r_state;
        w_owner_nxt    = r_owner;
        w_last_nxt     = r_last;
        w_wcnt_nxt     = r_wcnt;
        w_lcnt_nxt     = r_lcnt;
        w_set_timeout  = 1'b0;
        w_lock_err_nxt = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_wcnt_nxt = '0;
                w_lcnt_nxt = '0;
                if (w_req0 && w_req1) begin
                    // Tie: the master that did not finish last goes first
                    w_owner_nxt = ~r_last;
                    w_state_nxt = ST_ACTIVE;
                end else if (w_req0) begin
                    w_owner_nxt = 1'b0;
                    w_state_nxt = ST_ACTIVE;
                end else if (w_req1) begin
                    w_owner_nxt = 1'b1;
                    w_state_nxt = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                if (!w_own_req) begin
                    // Owner withdrew without completing; fairness history unchanged
                    w_state_nxt = ST_IDLE;
                    w_wcnt_nxt  = '0;
                end else if (!s_waitrequest_i) begin
                    w_last_nxt  = r_owner;
                    w_wcnt_nxt  = '0;
                    w_lcnt_nxt  = '0;
                    w_state_nxt = w_own_lock ? ST_HOLD : ST_IDLE;
                end else begin
                    // Stalled by the flash: count, saturate, never abort
                    if (r_wcnt != '1) begin
                        w_wcnt_nxt = r_wcnt + 1'b1;
                    end
                    if (r_wcnt >= WAIT_LAST) begin
                        w_set_timeout = 1'b1;
                    end
                end
            end
            ST_HOLD: begin
                if (w_own_req) begin
                    w_state_nxt = ST_ACTIVE;
                    w_lcnt_nxt  = '0;
                end else if (!w_own_lock) begin
                    w_state_nxt = ST_IDLE;
                    w_lcnt_nxt  = '0;
                end else if (r_lcnt == LOCK_LAST) begin
                    // Lock idled too long: take the port back
                    w_state_nxt    = ST_IDLE;
                    w_lcnt_nxt     = '0;
                    w_last_nxt     = r_owner;
                    w_lock_err_nxt = 1'b1;
                end else begin
                    w_lcnt_nxt = r_lcnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State, owner history, counters and status flags
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state    <= ST_IDLE;
            r_owner    <= 1'b0;
            r_last     <= 1'b1;
            r_wcnt     <= '0;
            r_lcnt     <= '0;
            r_timeout  <= 1'b0;
            r_lock_err <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_owner    <= w_owner_nxt;
            r_last     <= w_last_nxt;
            r_wcnt     <= w_wcnt_nxt;
            r_lcnt     <= w_lcnt_nxt;
            r_lock_err <= w_lock_err_nxt;
            // A new timeout takes priority over a clear in the same cycle
            if (w_set_timeout) begin
                r_timeout <= 1'b1;
            end else if (clr_i) begin
                r_timeout <= 1'b0;
            end
        end
    end

    // Slave command mux, master stalls and grant decode
    always_comb begin
        s_addr_o         = '0;
        s_data_o         = '0;
        s_write_o        = 1'b0;
        s_read_o         = 1'b0;
        s_byteenable_o   = 1'b0;
        if (w_active) begin
            s_addr_o       = r_owner ? m1_addr_i       : m0_addr_i;
            s_data_o       = r_owner ? m1_data_i       : m0_data_i;
            s_write_o      = r_owner ? m1_write_i      : m0_write_i;
            s_read_o       = r_owner ? m1_read_i       : m0_read_i;
            s_byteenable_o = r_owner ? m1_byteenable_i : m0_byteenable_i;
        end
        m0_waitrequest_o = ~(w_active && !r_owner && !s_waitrequest_i);
        m1_waitrequest_o = ~(w_active &&  r_owner && !s_waitrequest_i);
        grant_o          = 2'b00;
        if (r_state == ST_ACTIVE || r_state == ST_HOLD) begin
            grant_o = r_owner ? 2'b10 : 2'b01;
        end
    end

    assign m0_data_o   = s_data_i;
    assign m1_data_o   = s_data_i;
    assign timeout_o   = r_timeout;
    assign lock_err_o  = r_lock_err;
    assign dbg_state_o = r_state;

endmodule

// File: tb/tb_flash_host_arbiter.sv
// Directed testbench for flash_host_arbiter. The expected values are worked out by hand from the cycle-level behaviour.
// Inputs change 1 time unit after the rising edge. Outputs are checked 1 time unit after that.
module tb_flash_host_arbiter;

    localparam int ST_IDLE   = 0;
    localparam int ST_ACTIVE = 1;
    localparam int ST_HOLD   = 2;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic [3:0]  m0_addr_i, m1_addr_i;
    logic [15:0] m0_data_i, m1_data_i;
    logic        m0_write_i, m0_read_i, m0_byteenable_i, m0_lock_i;
    logic        m1_write_i, m1_read_i, m1_byteenable_i, m1_lock_i;
    logic [15:0] m0_data_o, m1_data_o;
    logic        m0_waitrequest_o, m1_waitrequest_o;
    logic [3:0]  s_addr_o;
    logic [15:0] s_data_o;
    logic        s_write_o, s_read_o, s_byteenable_o;
    logic [15:0] s_data_i;
    logic        s_waitrequest_i;
    logic [1:0]  grant_o;
    logic        timeout_o, lock_err_o, clr_i;
    logic [1:0]  dbg_state_o;

    int n_vec = 0;
    int n_err = 0;

    flash_host_arbiter dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .m0_addr_i(m0_addr_i), .m0_data_i(m0_data_i), .m0_write_i(m0_write_i),
        .m0_read_i(m0_read_i), .m0_byteenable_i(m0_byteenable_i), .m0_lock_i(m0_lock_i),
        .m0_data_o(m0_data_o), .m0_waitrequest_o(m0_waitrequest_o),
        .m1_addr_i(m1_addr_i), .m1_data_i(m1_data_i), .m1_write_i(m1_write_i),
        .m1_read_i(m1_read_i), .m1_byteenable_i(m1_byteenable_i), .m1_lock_i(m1_lock_i),
        .m1_data_o(m1_data_o), .m1_waitrequest_o(m1_waitrequest_o),
        .s_addr_o(s_addr_o), .s_data_o(s_data_o), .s_write_o(s_write_o),
        .s_read_o(s_read_o), .s_byteenable_o(s_byteenable_o),
        .s_data_i(s_data_i), .s_waitrequest_i(s_waitrequest_i),
        .grant_o(grant_o), .timeout_o(timeout_o), .lock_err_o(lock_err_o),
        .clr_i(clr_i), .dbg_state_o(dbg_state_o)
    );

    // Clock
    always #5 clk_i = ~clk_i;

    // Guard against a stuck run
    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk_i);
        #1;
    endtask

    task automatic clear_inputs();
        m0_addr_i = '0; m0_data_i = '0; m0_write_i = 0; m0_read_i = 0;
        m0_byteenable_i = 0; m0_lock_i = 0;
        m1_addr_i = '0; m1_data_i = '0; m1_write_i = 0; m1_read_i = 0;
        m1_byteenable_i = 0; m1_lock_i = 0;
        s_data_i = 16'h5A5A; s_waitrequest_i = 0; clr_i = 0;
    endtask

    task automatic reset_dut();
        rst_i = 1'b0;
        clear_inputs();
        repeat (2) @(posedge clk_i);
        #1;
        rst_i = 1'b1;
    endtask

    // Common per-cycle view of the arbiter
    task automatic check_view(input string tag, input int st, input int gnt,
                              input int wr0, input int wr1);
        check({tag, "_state"}, 32'(dbg_state_o), st);
        check({tag, "_grant"}, 32'(grant_o), gnt);
        check({tag, "_wr0"}, 32'(m0_waitrequest_o), wr0);
        check({tag, "_wr1"}, 32'(m1_waitrequest_o), wr1);
    endtask

    initial begin
        clear_inputs();
        // Reset state
        #3;
        check_view("rst", ST_IDLE, 0, 1, 1);
        check("rst_swrite", 32'(s_write_o), 0);
        check("rst_sread", 32'(s_read_o), 0);
        check("rst_timeout", 32'(timeout_o), 0);
        check("rst_lockerr", 32'(lock_err_o), 0);
        reset_dut();

        // Single m0 write with a ready slave
        next_cycle();
        m0_write_i = 1; m0_addr_i = 4'h2; m0_data_i = 16'h00A0; m0_byteenable_i = 1;
        #1;
        check_view("t1_c1", ST_IDLE, 0, 1, 1);
        check("t1_c1_swrite", 32'(s_write_o), 0);
        next_cycle(); #1;
        check_view("t1_c2", ST_ACTIVE, 1, 0, 1);
        check("t1_c2_swrite", 32'(s_write_o), 1);
        check("t1_c2_saddr", 32'(s_addr_o), 'h2);
        check("t1_c2_sdata", 32'(s_data_o), 'h00A0);
        check("t1_c2_sbe", 32'(s_byteenable_o), 1);
        next_cycle();
        m0_write_i = 0;
        #1;
        check_view("t1_c3", ST_IDLE, 0, 1, 1);
        check("t1_c3_swrite", 32'(s_write_o), 0);

        // Simultaneous reads, no locks: grants alternate m0, m1, m0, m1
        reset_dut();
        for (int i = 0; i < 4; i++) begin
            next_cycle();
            if (i == 0) begin
                m0_read_i = 1; m0_addr_i = 4'h5;
                m1_read_i = 1; m1_addr_i = 4'h6;
                s_data_i = 16'hC3C3;
            end
            #1;
            check_view("t2_idle", ST_IDLE, 0, 1, 1);
            next_cycle(); #1;
            check_view("t2_act", ST_ACTIVE, (i % 2 == 0) ? 1 : 2,
                       (i % 2 == 0) ? 0 : 1, (i % 2 == 0) ? 1 : 0);
            check("t2_sread", 32'(s_read_o), 1);
            check("t2_saddr", 32'(s_addr_o), (i % 2 == 0) ? 'h5 : 'h6);
            check("t2_rdata", 32'((i % 2 == 0) ? m0_data_o : m1_data_o), 'hC3C3);
        end
        next_cycle();
        m0_read_i = 0; m1_read_i = 0;
        #1;
        check_view("t2_end", ST_IDLE, 0, 1, 1);

        // m1 locked command sequence while m0 requests continuously
        reset_dut();
        next_cycle();
        m1_write_i = 1; m1_lock_i = 1; m1_addr_i = 4'h0; m1_data_i = 16'h0080;
        #1;
        check_view("t3_c1", ST_IDLE, 0, 1, 1);
        next_cycle();
        m0_read_i = 1; m0_addr_i = 4'h3;
        #1;
        check_view("t3_cmd", ST_ACTIVE, 2, 1, 0);
        check("t3_cmd_swrite", 32'(s_write_o), 1);
        check("t3_cmd_sdata", 32'(s_data_o), 'h0080);
        for (int j = 0; j < 3; j++) begin
            next_cycle();
            if (j == 0) begin
                m1_write_i = 0; m1_read_i = 1; m1_addr_i = 4'h1;
            end
            #1;
            check_view("t3_hold", ST_HOLD, 2, 1, 1);
            check("t3_hold_sread", 32'(s_read_o), 0);
            next_cycle(); #1;
            check_view("t3_poll", ST_ACTIVE, 2, 1, 0);
            check("t3_poll_sread", 32'(s_read_o), 1);
            check("t3_poll_saddr", 32'(s_addr_o), 'h1);
        end
        next_cycle();
        m1_read_i = 0; m1_lock_i = 0;
        #1;
        check_view("t3_unlock", ST_HOLD, 2, 1, 1);
        next_cycle(); #1;
        check_view("t3_idle", ST_IDLE, 0, 1, 1);
        next_cycle(); #1;
        check_view("t3_m0", ST_ACTIVE, 1, 0, 1);
        check("t3_m0_saddr", 32'(s_addr_o), 'h3);
        next_cycle();
        m0_read_i = 0;
        #1;
        check_view("t3_end", ST_IDLE, 0, 1, 1);

        // m0 holds a lock without using it: forced release after 256 HOLD cycles
        reset_dut();
        next_cycle();
        m0_write_i = 1; m0_lock_i = 1; m0_addr_i = 4'h4;
        #1;
        next_cycle(); #1;
        check_view("t4_act", ST_ACTIVE, 1, 0, 1);
        for (int k = 1; k <= 256; k++) begin
            next_cycle();
            if (k == 1) begin
                m0_write_i = 0; m1_read_i = 1; m1_addr_i = 4'h9;
            end
            #1;
            check("t4_hold_state", 32'(dbg_state_o), ST_HOLD);
            check("t4_hold_lockerr", 32'(lock_err_o), 0);
            check("t4_hold_wr1", 32'(m1_waitrequest_o), 1);
        end
        next_cycle(); #1;
        check_view("t4_rel", ST_IDLE, 0, 1, 1);
        check("t4_rel_lockerr", 32'(lock_err_o), 1);
        next_cycle(); #1;
        check_view("t4_m1", ST_ACTIVE, 2, 1, 0);
        check("t4_m1_lockerr", 32'(lock_err_o), 0);
        next_cycle();
        m1_read_i = 0; m0_lock_i = 0;
        #1;
        check_view("t4_end", ST_IDLE, 0, 1, 1);

        // Slave stalls 1024 ACTIVE cycles: timeout sets, transfer still completes
        reset_dut();
        next_cycle();
        m0_read_i = 1; m0_addr_i = 4'h7; s_waitrequest_i = 1;
        #1;
        for (int k = 1; k <= 1024; k++) begin
            next_cycle();
            // clear requested in the same cycle as the set: set must win
            clr_i = (k == 1024);
            #1;
            check("t5_stall_timeout", 32'(timeout_o), 0);
            check("t5_stall_wr0", 32'(m0_waitrequest_o), 1);
            check("t5_stall_sread", 32'(s_read_o), 1);
        end
        next_cycle();
        clr_i = 0;
        #1;
        check_view("t5_c1025", ST_ACTIVE, 1, 1, 1);
        check("t5_c1025_timeout", 32'(timeout_o), 1);
        next_cycle();
        s_waitrequest_i = 0;
        #1;
        check_view("t5_done", ST_ACTIVE, 1, 0, 1);
        next_cycle();
        m0_read_i = 0;
        #1;
        check_view("t5_idle", ST_IDLE, 0, 1, 1);
        check("t5_sticky", 32'(timeout_o), 1);
        next_cycle();
        clr_i = 1;
        #1;
        check("t5_clr_same", 32'(timeout_o), 1);
        next_cycle();
        clr_i = 0;
        #1;
        check("t5_cleared", 32'(timeout_o), 0);

        // Asynchronous reset while ACTIVE with the slave stalled
        reset_dut();
        next_cycle();
        m0_read_i = 1; m0_addr_i = 4'hB; s_waitrequest_i = 1;
        #1;
        next_cycle(); #1;
        check_view("t6_act", ST_ACTIVE, 1, 1, 1);
        check("t6_act_sread", 32'(s_read_o), 1);
        #1;
        rst_i = 0;
        #1;
        check_view("t6_rst", ST_IDLE, 0, 1, 1);
        check("t6_rst_sread", 32'(s_read_o), 0);
        check("t6_rst_saddr", 32'(s_addr_o), 0);
        m0_read_i = 0; s_waitrequest_i = 0;
        next_cycle();
        rst_i = 1;
        next_cycle();
        m1_read_i = 1; m1_addr_i = 4'hE;
        #1;
        check_view("t6_c1", ST_IDLE, 0, 1, 1);
        next_cycle(); #1;
        check_view("t6_m1", ST_ACTIVE, 2, 1, 0);
        check("t6_m1_saddr", 32'(s_addr_o), 'hE);
        next_cycle();
        m1_read_i = 0;
        #1;
        check_view("t6_end", ST_IDLE, 0, 1, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
